// File: rtl/smc777_ram_arbiter.sv
// smc777_ram_arbiter: shares dpram port A between ioctl download, video fetch and the tv80 CPU.
// Download preempts everything; video outranks the CPU, which is held off through cpu_wait_n.
module smc777_ram_arbiter #(
  parameter int          AW          = 14,
  parameter logic [7:0]  VID_DL_FILL = 8'h00
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_valid,
  output logic          vid_overrun,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_d,
  output logic          ram_wren,
  input  logic [7:0]    ram_q
);
  typedef enum logic [2:0] {IDLE, DL, V_ADDR, V_DATA, C_ADDR, C_DATA} state_t;
  state_t        r_state, w_next;
  logic          r_vid_pend, r_cpu_done, r_vid_valid, r_vid_overrun;
  logic [AW-1:0] r_vid_addr;
  logic [7:0]    r_cpu_dout, r_vid_data;
  logic          w_vbusy, w_vid_acc, w_vid_go, w_cpu_go, w_dl_fill, w_cpu_set, w_unused;

  assign w_unused  = ^cpu_addr[15:AW];
  assign w_vbusy   = (r_state == V_ADDR) || (r_state == V_DATA);
  assign w_vid_acc = vid_req & ~r_vid_pend & ~w_vbusy;
  assign w_cpu_go  = cpu_req & ~r_cpu_done;
  assign w_vid_go  = (r_state == IDLE) && !ioctl_download && (r_vid_pend || vid_req);
  // Video requests seen during download, or cut short by it, are answered with fill data.
  assign w_dl_fill = ((r_state == DL) && r_vid_pend) || (w_vbusy && ioctl_download);
  assign w_cpu_set = ((r_state == C_ADDR) && cpu_we) || ((r_state == C_DATA) && !ioctl_download);

  assign cpu_wait_n  = ~reset_n | ~w_cpu_go;
  assign cpu_dout    = r_cpu_dout;
  assign vid_data    = r_vid_data;
  assign vid_valid   = r_vid_valid;
  assign vid_overrun = r_vid_overrun;
  assign ram_addr    = (r_state == DL)     ? ioctl_addr :
                       (r_state == V_ADDR) ? r_vid_addr :
                       (r_state == C_ADDR) ? cpu_addr[AW-1:0] : '0;
  assign ram_d       = (r_state == DL) ? ioctl_dout : (r_state == C_ADDR) ? cpu_din : 8'h00;
  assign ram_wren    = (r_state == DL) ? ioctl_wr : ((r_state == C_ADDR) && cpu_we);

  always_comb begin
    w_next = r_state;
    if (ioctl_download) w_next = DL;
    else
      case (r_state)
        IDLE:    w_next = w_vid_go ? V_ADDR : w_cpu_go ? C_ADDR : IDLE;
        V_ADDR:  w_next = V_DATA;
        C_ADDR:  w_next = cpu_we ? IDLE : C_DATA;
        default: w_next = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state       <= IDLE;
      r_vid_pend    <= 1'b0;
      r_cpu_done    <= 1'b0;
      r_vid_valid   <= 1'b0;
      r_vid_overrun <= 1'b0;
      r_vid_addr    <= '0;
      r_cpu_dout    <= 8'h00;
      r_vid_data    <= 8'h00;
    end else begin
      r_state       <= w_next;
      r_vid_pend    <= (w_vid_go || ((r_state == DL) && r_vid_pend)) ? 1'b0 : (r_vid_pend | w_vid_acc);
      r_vid_overrun <= r_vid_overrun | (vid_req & ~w_vid_acc);
      r_vid_valid   <= w_dl_fill || (r_state == V_DATA);
      r_cpu_done    <= cpu_req & (r_cpu_done | w_cpu_set);
      if (w_vid_acc) r_vid_addr <= vid_addr;
      if (w_dl_fill) r_vid_data <= VID_DL_FILL;
      else if (r_state == V_DATA) r_vid_data <= ram_q;
      if ((r_state == C_DATA) && !ioctl_download) r_cpu_dout <= ram_q;
    end
endmodule
